// File: rtl/hazard_pkg.sv
// Shared constants, stage-tag type and tag-match helper for hazard_forward_ctrl.
package hazard_pkg;

  localparam int unsigned HZ_REG_AW = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [HZ_REG_AW-1:0] PC_REG_DEF = 4'd15;
  localparam logic [HZ_REG_AW-1:0] LR_REG_DEF = 4'd14;

  typedef struct packed {
    logic                 valid;
    logic                 rf_en;
    logic                 load;
    logic [HZ_REG_AW-1:0] rd;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = stage_tag_t'({(HZ_REG_AW+3){1'b0}});

  // R15 comes from the PC path, so it can never be satisfied by a forward.
  function automatic logic tag_match(input stage_tag_t tag,
                                     input logic [HZ_REG_AW-1:0] src,
                                     input logic used,
                                     input logic [HZ_REG_AW-1:0] pc_reg);
    return used & tag.valid & tag.rf_en & (tag.rd == src) & (src != pc_reg);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// One source operand against the EX/MEM/WB tags, producing a 2-bit forward select.
module fwd_select
  import hazard_pkg::*;
#(
  parameter logic [HZ_REG_AW-1:0] PC_REG = PC_REG_DEF
) (
  input  logic [HZ_REG_AW-1:0] src,
  input  logic                 used,
  input  stage_tag_t           ex_tag,
  input  stage_tag_t           mem_tag,
  input  stage_tag_t           wb_tag,
  output logic [1:0]           sel,
  output logic                 ex_hit
);

  logic ex_m_s;
  logic mem_m_s;
  logic wb_m_s;

  assign ex_m_s  = tag_match(ex_tag,  src, used, PC_REG);
  assign mem_m_s = tag_match(mem_tag, src, used, PC_REG);
  assign wb_m_s  = tag_match(wb_tag,  src, used, PC_REG);
  assign ex_hit  = ex_m_s;

  // Youngest producer wins so the consumer always sees the newest value.
  always_comb begin
    sel = FWD_RF;
    if (ex_m_s) begin
      sel = FWD_EX;
    end else if (mem_m_s) begin
      sel = FWD_MEM;
    end else if (wb_m_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: shadow EX/MEM/WB tag pipe, forward selects, load-use stall
// and branch flush. Optional saturating perf counters under HAZARD_PERF_CNT_EN.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned          REG_AW = HZ_REG_AW,
  parameter int unsigned          CNT_W  = 16,
  parameter logic [HZ_REG_AW-1:0] PC_REG = PC_REG_DEF,
  parameter logic [HZ_REG_AW-1:0] LR_REG = LR_REG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_valid,
  input  logic [REG_AW-1:0] ID_Rn,
  input  logic [REG_AW-1:0] ID_Rm,
  input  logic [REG_AW-1:0] ID_Rd,
  input  logic              ID_use_rn,
  input  logic              ID_use_rm,
  input  logic              ID_use_rd,
  input  logic              ID_RF_enable,
  input  logic              ID_load_instr,
  input  logic              ID_BL_instr,
  input  logic              branch_taken,
  output logic [1:0]        S_PA,
  output logic [1:0]        S_PB,
  output logic [1:0]        S_PD,
  output logic              pc_le,
  output logic              ifid_le,
  output logic              idex_nop,
  output logic              flush_ifid,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  stage_tag_t ex_tag_r;
  stage_tag_t mem_tag_r;
  stage_tag_t wb_tag_r;

  logic hit_a_s;
  logic hit_b_s;
  logic hit_d_s;
  logic stall_s;
  logic flush_s;

  fwd_select #(.PC_REG(PC_REG)) u_sel_a (
    .src(ID_Rn), .used(ID_use_rn),
    .ex_tag(ex_tag_r), .mem_tag(mem_tag_r), .wb_tag(wb_tag_r),
    .sel(S_PA), .ex_hit(hit_a_s)
  );

  fwd_select #(.PC_REG(PC_REG)) u_sel_b (
    .src(ID_Rm), .used(ID_use_rm),
    .ex_tag(ex_tag_r), .mem_tag(mem_tag_r), .wb_tag(wb_tag_r),
    .sel(S_PB), .ex_hit(hit_b_s)
  );

  fwd_select #(.PC_REG(PC_REG)) u_sel_d (
    .src(ID_Rd), .used(ID_use_rd),
    .ex_tag(ex_tag_r), .mem_tag(mem_tag_r), .wb_tag(wb_tag_r),
    .sel(S_PD), .ex_hit(hit_d_s)
  );

  // A load in EX has no data yet; its consumer waits one cycle and then takes it from MEM.
  assign stall_s = ex_tag_r.load & (hit_a_s | hit_b_s | hit_d_s);
  // Stall beats flush; gating by reset keeps flush quiet while the tags are held clear.
  assign flush_s = branch_taken & ~stall_s & reset;

  assign stall      = stall_s;
  assign flush_ifid = flush_s;
  assign pc_le      = ~stall_s;
  assign ifid_le    = ~stall_s;
  assign idex_nop   = stall_s;

  // Shadow tag pipeline; a stall drops a bubble into EX while older stages keep moving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_tag_r  <= TAG_BUBBLE;
      mem_tag_r <= TAG_BUBBLE;
      wb_tag_r  <= TAG_BUBBLE;
    end else begin
      wb_tag_r  <= mem_tag_r;
      mem_tag_r <= ex_tag_r;
      if (stall_s) begin
        ex_tag_r <= TAG_BUBBLE;
      end else begin
        ex_tag_r <= '{valid: ID_valid,
                      rf_en: ID_RF_enable | ID_BL_instr,
                      load:  ID_load_instr,
                      rd:    ID_BL_instr ? LR_REG : ID_Rd};
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;
`else
  assign stall_count = {CNT_W{1'b0}};
  assign flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage ARM pipeline (IF/ID/EX/MEM/WB). It keeps its own shadow pipeline of destination tags for EX, MEM and WB. From these tags it drives the PA/PB/PD forwarding mux selects, the load-use stall, and the IF/ID flush on a taken branch. It replaces the ad-hoc hazard wiring between the control unit, register file muxes and PC.

Parameters:
REG_AW, 4, register address width (16 architectural registers)
CNT_W, 16, width of the optional performance counters
PC_REG, 15, register index never forwarded (R15 is read from the PC path)
LR_REG, 14, link register written by BL

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
ID_valid  in  1  ID stage holds a real instruction (not a bubble)
ID_Rn  in  REG_AW  first source register
ID_Rm  in  REG_AW  second source register
ID_Rd  in  REG_AW  destination register; also the third source for stores and shifts
ID_use_rn, ID_use_rm, ID_use_rd  in  1 each  corresponding source is actually read
ID_RF_enable  in  1  instruction writes ID_Rd
ID_load_instr  in  1  instruction is a load
ID_BL_instr  in  1  instruction is BL; writes LR_REG
branch_taken  in  1  taken branch resolved in ID this cycle
S_PA, S_PB, S_PD  out  2 each  forwarding select: 00 RF, 01 EX, 10 MEM, 11 WB
pc_le  out  1  PC load enable
ifid_le  out  1  IF/ID register load enable
idex_nop  out  1  insert bubble into ID/EX
flush_ifid  out  1  clear IF/ID at next edge
stall  out  1  load-use stall active
stall_count, flush_count  out  CNT_W each  performance counters

Behaviour:
- Reset (reset=0, asynchronous):
  - EX, MEM and WB tags are cleared (valid=0).
  - Outputs: S_*=00, pc_le=1, ifid_le=1, idex_nop=0, flush_ifid=0, stall=0, counters=0.
- Tag format: {valid, rf_en, load, rd}.
- Tag advance at each rising edge:
  - WB<=MEM; MEM<=EX.
  - EX<=bubble (valid=0) if stall=1.
  - Otherwise EX<={ID_valid, ID_RF_enable|ID_BL_instr, ID_load_instr, ID_BL_instr ? LR_REG : ID_Rd}.
- Forwarding (combinational, zero latency):
  - A source "matches" a stage when: source is used, stage valid=1, stage rf_en=1, stage rd==source, and source!=PC_REG.
  - Priority is EX > MEM > WB > RF.
  - S_PA is computed from Rn, S_PB from Rm, S_PD from Rd.
- Load-use stall: stall=1 when the EX tag has load=1 and any used source matches EX. While stalled:
  - pc_le=0, ifid_le=0, idex_nop=1.
  - Lasts exactly one cycle: the next edge puts a bubble into EX and moves the load to MEM, where its result forwards via select 10.
- Branch flush: flush_ifid=branch_taken & ~stall, with pc_le=1.
  - If stall and branch_taken are asserted together, the stall wins: no flush that cycle, and the branch is re-evaluated after the stall.
- A load that targets PC_REG never stalls and never forwards.
- Tags from instructions that do not write the register file (rf_en=0) never forward.
- Reset asserted mid-stall: all outputs go to their reset values immediately; the stalled instruction is discarded by the pipeline's own reset.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count increments on every clock with stall=1.
  - flush_count increments on every clock with flush_ifid=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are still present, tied to 0, and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - fwd select constants FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11;
  - PC_REG and LR_REG defaults;
  - stage tag struct typedef.
- Sub-module fwd_select: combinational priority comparator (one source vs three tags → 2-bit select), instantiated three times.

Test Plan:
- Reset low at t=0, release after 3 ns → S_*=00, pc_le=1, ifid_le=1, stall=0, no tags valid.
- ADD R1 (rf_en) then SUB reading Rn=R1 next cycle → S_PA=01. Two cycles later the same read gives S_PA=10; three cycles later S_PA=11.
- LDR R2 followed by ADD reading Rm=R2 → exactly one cycle with stall=1, pc_le=0, ifid_le=0, idex_nop=1. Next cycle S_PB=10, stall=0.
- branch_taken=1 with no hazard → flush_ifid=1, pc_le=1 for one cycle. Same cycle as a load-use stall → flush_ifid=0; flush occurs the cycle after.
- BL in EX, then an instruction reading Rd=R14 → S_PD=01. A read of R15 with an EX tag rd=15 → S_*=00.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls and 2 flushes → stall_count=3, flush_count=2. Without the macro → both stay 0.
